// File: rtl/rk_xfer_seq.sv
// rk_xfer_seq: RKV11 sector transfer sequencer.
// Walks word count / bus address / disk address for one RK transfer and moves
// words between the uC-owned 256-word sector buffer and QBUS memory through
// the DMA master. Reports live counters and sticky error flags.
module rk_xfer_seq #(
   parameter int SECTORS   = 12,
   parameter int CYLINDERS = 203,
   parameter int WPS       = 256
) (
   input  logic        qclk,
   input  logic        init_L,
   input  logic        start,
   input  logic [1:0]  func,
   input  logic [15:0] wc_in,
   input  logic [21:0] ba_in,
   input  logic        inh_ba,
   input  logic [12:0] da_in,
   output logic        sect_req,
   output logic        sect_wr,
   output logic [12:0] sect_lba,
   input  logic        sect_ack,
   output logic [7:0]  buf_addr,
   output logic        buf_we,
   output logic [15:0] buf_wdata,
   input  logic [15:0] buf_rdata,
   output logic        dma_req,
   output logic        dma_wr,
   output logic [21:0] dma_addr,
   output logic [15:0] dma_wdata,
   input  logic [15:0] dma_rdata,
   input  logic        dma_done,
   input  logic        dma_nxm,
   output logic        busy,
   output logic        done,
   output logic [15:0] wc_out,
   output logic [21:0] ba_out,
   output logic [12:0] da_out,
   output logic        err_ovr,
   output logic        err_nxs,
   output logic        err_nxc,
   output logic        err_nxm,
   output logic        err_wce
);

   localparam logic [3:0] S_IDLE  = 4'd0;
   localparam logic [3:0] S_CHECK = 4'd1;
   localparam logic [3:0] S_FILL  = 4'd2;
   localparam logic [3:0] S_RDBUF = 4'd3;
   localparam logic [3:0] S_DMA   = 4'd4;
   localparam logic [3:0] S_STORE = 4'd5;
   localparam logic [3:0] S_PAD   = 4'd6;
   localparam logic [3:0] S_FLUSH = 4'd7;
   localparam logic [3:0] S_ADV   = 4'd8;
   localparam logic [3:0] S_FIN   = 4'd9;

   localparam logic [1:0] F_WR = 2'b01;
   localparam logic [1:0] F_RD = 2'b10;
   localparam logic [1:0] F_WC = 2'b11;

   logic [3:0]  state_q, state_d;
   logic [1:0]  func_q, func_d;
   logic [15:0] wc_q, wc_d;
   logic [21:0] ba_q, ba_d;
   logic [12:0] da_q, da_d;
   logic        inh_q, inh_d;
   logic [8:0]  w_q, w_d;        // word index within the sector buffer, 0..WPS
   logic [15:0] data_q, data_d;  // word in flight (DMA read result or buffer word)
   logic        rdp_q, rdp_d;    // first DMA cycle of a read: buffer data arrives now
   logic        ovr_q, ovr_d;
   logic        nxs_q, nxs_d;
   logic        nxc_q, nxc_d;
   logic        nxm_q, nxm_d;
   logic        wce_q, wce_d;

   logic [7:0]  cyl;
   logic        sur;
   logic [3:0]  sec;
   logic [8:0]  cyl_inc;
   logic [15:0] wc_inc;
   logic [8:0]  w_inc;
   logic [12:0] lba;
   logic        is_wr, is_rd, is_wc;

   assign cyl     = da_q[12:5];
   assign sur     = da_q[4];
   assign sec     = da_q[3:0];
   assign cyl_inc = {1'b0, cyl} + 9'd1;
   assign wc_inc  = wc_q + 16'd1;
   assign w_inc   = w_q + 9'd1;
   assign is_wr   = (func_q == F_WR);
   assign is_rd   = (func_q == F_RD);
   assign is_wc   = (func_q == F_WC);

   // Linear sector number: two surfaces of SECTORS each per cylinder.
   assign lba = 13'(cyl) * 13'(2 * SECTORS) + (sur ? 13'(SECTORS) : 13'd0) + 13'(sec);

   // Next-state and datapath updates for the transfer sequencer.
   always_comb begin
      state_d = state_q;
      func_d  = func_q;
      wc_d    = wc_q;
      ba_d    = ba_q;
      da_d    = da_q;
      inh_d   = inh_q;
      w_d     = w_q;
      data_d  = data_q;
      rdp_d   = 1'b0;
      ovr_d   = ovr_q;
      nxs_d   = nxs_q;
      nxc_d   = nxc_q;
      nxm_d   = nxm_q;
      wce_d   = wce_q;
      case (state_q)
         S_IDLE: begin
            if (start && (func != 2'b00)) begin
               func_d  = func;
               wc_d    = wc_in;
               ba_d    = ba_in & ~22'd1;
               da_d    = da_in;
               inh_d   = inh_ba;
               w_d     = 9'd0;
               ovr_d   = 1'b0;
               nxs_d   = 1'b0;
               nxc_d   = 1'b0;
               nxm_d   = 1'b0;
               wce_d   = 1'b0;
               state_d = S_CHECK;
            end
         end
         S_CHECK: begin
            if (sec >= 4'(SECTORS)) begin
               nxs_d   = 1'b1;
               state_d = S_FIN;
            end else if ({1'b0, cyl} >= 9'(CYLINDERS)) begin
               nxc_d   = 1'b1;
               state_d = S_FIN;
            end else if (is_wr) begin
               w_d     = 9'd0;
               state_d = S_DMA;
            end else begin
               state_d = S_FILL;
            end
         end
         S_FILL: begin
            if (sect_ack) begin
               w_d     = 9'd0;
               state_d = is_rd ? S_RDBUF : S_DMA;
            end
         end
         S_RDBUF: begin
            rdp_d   = 1'b1;
            state_d = S_DMA;
         end
         S_DMA: begin
            // Capture the buffer word so dma_wdata stays stable for the whole request.
            if (rdp_q) data_d = buf_rdata;
            if (dma_nxm) begin
               nxm_d   = 1'b1;
               state_d = S_FIN;
            end else if (dma_done) begin
               wc_d = wc_inc;
               if (!inh_q) ba_d = ba_q + 22'd2;
               if (is_rd) begin
                  w_d = w_inc;
                  if (wc_inc == 16'd0)         state_d = S_FIN;
                  else if (w_inc == 9'(WPS))   state_d = S_ADV;
                  else                         state_d = S_RDBUF;
               end else begin
                  data_d  = dma_rdata;
                  state_d = S_STORE;
               end
            end
         end
         S_STORE: begin
            w_d = w_inc;
            if (is_wc) begin
               // buf_addr has sat on w since the DMA cycle, so buf_rdata is buf[w].
               if (buf_rdata != data_q) begin
                  wce_d   = 1'b1;
                  state_d = S_FIN;
               end else if (wc_q == 16'd0)   state_d = S_FIN;
               else if (w_inc == 9'(WPS))    state_d = S_ADV;
               else                          state_d = S_DMA;
            end else begin
               if (wc_q == 16'd0)            state_d = (w_inc < 9'(WPS)) ? S_PAD : S_FLUSH;
               else if (w_inc == 9'(WPS))    state_d = S_FLUSH;
               else                          state_d = S_DMA;
            end
         end
         S_PAD: begin
            w_d = w_inc;
            if (w_q == 9'(WPS - 1)) state_d = S_FLUSH;
         end
         S_FLUSH: begin
            if (sect_ack) state_d = (wc_q == 16'd0) ? S_FIN : S_ADV;
         end
         S_ADV: begin
            w_d     = 9'd0;
            state_d = is_wr ? S_DMA : S_FILL;
            if (sec == 4'(SECTORS - 1)) begin
               if (sur) begin
                  // Running off the last cylinder leaves da at the last valid sector.
                  if (cyl_inc == 9'(CYLINDERS)) begin
                     ovr_d   = 1'b1;
                     state_d = S_FIN;
                  end else begin
                     da_d = {cyl_inc[7:0], 1'b0, 4'd0};
                  end
               end else begin
                  da_d = {cyl, 1'b1, 4'd0};
               end
            end else begin
               da_d = {cyl, sur, sec + 4'd1};
            end
         end
         S_FIN: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and counter registers; init_L clears everything immediately.
   always_ff @(posedge qclk or negedge init_L) begin
      if (!init_L) begin
         state_q <= S_IDLE;
         func_q  <= 2'b00;
         wc_q    <= 16'd0;
         ba_q    <= 22'd0;
         da_q    <= 13'd0;
         inh_q   <= 1'b0;
         w_q     <= 9'd0;
         data_q  <= 16'd0;
         rdp_q   <= 1'b0;
         ovr_q   <= 1'b0;
         nxs_q   <= 1'b0;
         nxc_q   <= 1'b0;
         nxm_q   <= 1'b0;
         wce_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         func_q  <= func_d;
         wc_q    <= wc_d;
         ba_q    <= ba_d;
         da_q    <= da_d;
         inh_q   <= inh_d;
         w_q     <= w_d;
         data_q  <= data_d;
         rdp_q   <= rdp_d;
         ovr_q   <= ovr_d;
         nxs_q   <= nxs_d;
         nxc_q   <= nxc_d;
         nxm_q   <= nxm_d;
         wce_q   <= wce_d;
      end
   end

   // Handshake, buffer and status outputs decoded from registered state.
   always_comb begin
      sect_req  = (state_q == S_FILL) || (state_q == S_FLUSH);
      sect_wr   = (state_q == S_FLUSH);
      sect_lba  = sect_req ? lba : 13'd0;
      dma_req   = (state_q == S_DMA);
      dma_wr    = dma_req && is_rd;
      dma_addr  = ba_q;
      dma_wdata = dma_wr ? (rdp_q ? buf_rdata : data_q) : 16'd0;
      buf_addr  = w_q[7:0];
      buf_we    = ((state_q == S_STORE) && is_wr) || (state_q == S_PAD);
      buf_wdata = ((state_q == S_STORE) && is_wr) ? data_q : 16'd0;
      busy      = (state_q != S_IDLE) && (state_q != S_FIN);
      done      = (state_q == S_FIN);
      wc_out    = wc_q;
      ba_out    = ba_q;
      da_out    = da_q;
      err_ovr   = ovr_q;
      err_nxs   = nxs_q;
      err_nxc   = nxc_q;
      err_nxm   = nxm_q;
      err_wce   = wce_q;
   end

endmodule

// File: tb/tb_rk_xfer_seq.sv
// Directed bench for rk_xfer_seq with behavioural uC sector buffer and DMA slave.
module tb_rk_xfer_seq;
   logic        qclk = 1'b0;
   logic        init_L = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  func = 2'b00;
   logic [15:0] wc_in = 16'd0;
   logic [21:0] ba_in = 22'd0;
   logic        inh_ba = 1'b0;
   logic [12:0] da_in = 13'd0;
   logic        sect_req, sect_wr;
   logic [12:0] sect_lba;
   logic        sect_ack = 1'b0;
   logic [7:0]  buf_addr;
   logic        buf_we;
   logic [15:0] buf_wdata;
   logic [15:0] buf_rdata = 16'd0;
   logic        dma_req, dma_wr;
   logic [21:0] dma_addr;
   logic [15:0] dma_wdata;
   logic [15:0] dma_rdata = 16'd0;
   logic        dma_done = 1'b0;
   logic        dma_nxm = 1'b0;
   logic        busy, done;
   logic [15:0] wc_out;
   logic [21:0] ba_out;
   logic [12:0] da_out;
   logic        err_ovr, err_nxs, err_nxc, err_nxm, err_wce;

   int checks = 0;
   int errors = 0;

   // model controls (written by the stimulus block only)
   logic        clr = 1'b0;
   int          nxm_at = -1;
   int          bad_idx = -1;
   logic        rd_mode = 1'b0;
   logic [15:0] rd_val = 16'd0;

   // model state (written by the model blocks only)
   logic [15:0] bufmem [256];
   logic [12:0] fill_lba [8];
   logic [12:0] flush_lba [8];
   int          fill_cnt = 0, flush_cnt = 0, sdly = 0;
   logic [21:0] alog [1024];
   logic [15:0] dlog [1024];
   int          hs_cnt = 0, wr_cnt = 0;
   logic        ddly = 1'b0;

   rk_xfer_seq dut (
      .qclk(qclk), .init_L(init_L), .start(start), .func(func), .wc_in(wc_in),
      .ba_in(ba_in), .inh_ba(inh_ba), .da_in(da_in), .sect_req(sect_req),
      .sect_wr(sect_wr), .sect_lba(sect_lba), .sect_ack(sect_ack),
      .buf_addr(buf_addr), .buf_we(buf_we), .buf_wdata(buf_wdata),
      .buf_rdata(buf_rdata), .dma_req(dma_req), .dma_wr(dma_wr),
      .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_rdata(dma_rdata),
      .dma_done(dma_done), .dma_nxm(dma_nxm), .busy(busy), .done(done),
      .wc_out(wc_out), .ba_out(ba_out), .da_out(da_out), .err_ovr(err_ovr),
      .err_nxs(err_nxs), .err_nxc(err_nxc), .err_nxm(err_nxm), .err_wce(err_wce)
   );

   always #25 qclk = ~qclk;

   // uC side: sector buffer with 1-cycle read, fills load {lba[7:0], index}
   always @(posedge qclk) begin
      sect_ack <= 1'b0;
      if (buf_we) bufmem[buf_addr] <= buf_wdata;
      buf_rdata <= bufmem[buf_addr];
      if (clr) begin
         fill_cnt <= 0; flush_cnt <= 0; sdly <= 0;
      end else if (sect_req && !sect_ack) begin
         if (sdly == 3) begin
            sdly <= 0;
            sect_ack <= 1'b1;
            if (sect_wr) begin
               if (flush_cnt < 8) flush_lba[flush_cnt] <= sect_lba;
               flush_cnt <= flush_cnt + 1;
            end else begin
               if (fill_cnt < 8) fill_lba[fill_cnt] <= sect_lba;
               fill_cnt <= fill_cnt + 1;
               for (int i = 0; i < 256; i++) bufmem[i] <= {sect_lba[7:0], 8'(i)};
            end
         end else begin
            sdly <= sdly + 1;
         end
      end
   end

   // DMA slave: answers each request on its second cycle
   always @(posedge qclk) begin
      dma_done <= 1'b0;
      dma_nxm  <= 1'b0;
      if (clr) begin
         hs_cnt <= 0; wr_cnt <= 0; ddly <= 1'b0;
      end else if (dma_req && !dma_done && !dma_nxm) begin
         if (ddly) begin
            ddly <= 1'b0;
            hs_cnt <= hs_cnt + 1;
            if (hs_cnt < 1024) alog[hs_cnt] <= dma_addr;
            if (hs_cnt == nxm_at) begin
               dma_nxm <= 1'b1;
            end else begin
               dma_done <= 1'b1;
               dma_rdata <= rd_mode ? ((hs_cnt == bad_idx) ? 16'hBEEF : 16'(hs_cnt)) : rd_val;
               if (dma_wr) begin
                  if (wr_cnt < 1024) dlog[wr_cnt] <= dma_wdata;
                  wr_cnt <= wr_cnt + 1;
               end
            end
         end else begin
            ddly <= 1'b1;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clr_models();
      @(negedge qclk); clr = 1'b1;
      @(negedge qclk); clr = 1'b0;
   endtask

   task automatic do_start(input logic [1:0] f, input logic [15:0] wc, input logic [21:0] ba,
                           input logic inh, input logic [12:0] da);
      @(negedge qclk);
      func = f; wc_in = wc; ba_in = ba; inh_ba = inh; da_in = da; start = 1'b1;
      @(negedge qclk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int max, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max; i++) begin
         @(negedge qclk);
         if (done) begin ok = 1'b1; break; end
      end
   endtask

   initial begin
      bit ok;
      int bad;
      logic [15:0] e;

      // ---- reset state
      repeat (3) @(negedge qclk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_reqs", {sect_req, dma_req, buf_we}, 0);
      chk("rst_ctrs", {wc_out, ba_out, da_out} != 0, 0);
      chk("rst_errs", {err_ovr, err_nxs, err_nxc, err_nxm, err_wce}, 0);
      init_L = 1'b1;
      clr_models();

      // ---- read 256 words, cyl 0 sec 0, ba 0o1000
      do_start(2'b10, 16'hFF00, 22'o1000, 1'b0, 13'd0);
      chk("rd_req_early", sect_req, 0);
      chk("rd_busy", busy, 1);
      @(negedge qclk);
      chk("rd_req_2cyc", {sect_req, sect_wr}, 2'b10);
      wait_done(6000, ok);
      chk("rd_done", ok, 1);
      chk("rd_busy_fin", busy, 0);
      chk("rd_wc", wc_out, 16'h0000);
      chk("rd_ba", ba_out, 22'o2000);
      chk("rd_da", da_out, 0);
      chk("rd_fills", fill_cnt, 1);
      chk("rd_lba", fill_lba[0], 0);
      chk("rd_flush", flush_cnt, 0);
      chk("rd_wrcnt", wr_cnt, 256);
      bad = 0;
      for (int k = 0; k < 256; k++)
         if (alog[k] !== 22'o1000 + 22'(2 * k) || dlog[k] !== 16'(k)) bad++;
      chk("rd_words", bad, 0);
      chk("rd_errs", {err_ovr, err_nxs, err_nxc, err_nxm, err_wce}, 0);

      // ---- write 1 word: padded sector flushed to lba 0
      clr_models();
      rd_val = 16'o123456;
      do_start(2'b01, 16'hFFFF, 22'h001000, 1'b0, 13'd0);
      chk("wr_req_early", dma_req, 0);
      @(negedge qclk);
      chk("wr_req_2cyc", {dma_req, dma_wr}, 2'b10);
      chk("wr_addr", dma_addr, 22'h001000);
      wait_done(3000, ok);
      chk("wr_done", ok, 1);
      chk("wr_flush", flush_cnt, 1);
      chk("wr_flush_lba", flush_lba[0], 0);
      chk("wr_fills", fill_cnt, 0);
      chk("wr_buf0", bufmem[0], 16'o123456);
      bad = 0;
      for (int k = 1; k < 256; k++) if (bufmem[k] !== 16'd0) bad++;
      chk("wr_pad", bad, 0);
      chk("wr_wc", wc_out, 0);
      chk("wr_ba", ba_out, 22'h001002);

      // ---- read spanning sectors from cyl 1 sur 1 sec 11
      clr_models();
      do_start(2'b10, 16'hFE00, 22'd0, 1'b0, {8'd1, 1'b1, 4'd11});
      wait_done(6000, ok);
      chk("sp_done", ok, 1);
      chk("sp_fills", fill_cnt, 2);
      chk("sp_lba0", fill_lba[0], 47);
      chk("sp_lba1", fill_lba[1], 48);
      chk("sp_da", da_out, {8'd2, 1'b0, 4'd0});
      chk("sp_wc", wc_out, 0);
      chk("sp_ba", ba_out, 22'h000400);
      bad = 0;
      for (int k = 0; k < 512; k++) begin
         e = {(k < 256) ? 8'd47 : 8'd48, 8'(k)};
         if (alog[k] !== 22'(2 * k) || dlog[k] !== e) bad++;
      end
      chk("sp_words", bad, 0);

      // ---- overrun past the last cylinder
      clr_models();
      do_start(2'b10, 16'hFE00, 22'd0, 1'b0, {8'd202, 1'b1, 4'd11});
      wait_done(6000, ok);
      chk("ov_done", ok, 1);
      chk("ov_err", err_ovr, 1);
      chk("ov_wc", wc_out, 16'hFF00);
      chk("ov_da", da_out, {8'd202, 1'b1, 4'd11});
      chk("ov_fill", {fill_cnt[3:0], fill_lba[0]}, {4'd1, 13'd4871});
      chk("ov_wrcnt", wr_cnt, 256);

      // ---- non-existent memory on third word
      clr_models();
      nxm_at = 2;
      do_start(2'b10, 16'hFFF0, 22'h000100, 1'b0, 13'd0);
      wait_done(3000, ok);
      chk("nxm_done", ok, 1);
      chk("nxm_err", {err_nxm, err_ovr}, 2'b10);
      chk("nxm_wc", wc_out, 16'hFFF2);
      chk("nxm_ba", ba_out, 22'h000104);
      repeat (20) @(negedge qclk);
      chk("nxm_hs", hs_cnt, 3);
      chk("nxm_wrcnt", wr_cnt, 2);
      chk("nxm_quiet", {sect_req, dma_req, fill_cnt[3:0], flush_cnt[3:0]}, {2'b00, 4'd1, 4'd0});
      nxm_at = -1;

      // ---- bad sector / bad cylinder
      clr_models();
      do_start(2'b10, 16'hFFF0, 22'd0, 1'b0, 13'd12);
      wait_done(50, ok);
      chk("nxs_done", ok, 1);
      chk("nxs_err", {err_nxs, err_nxc, err_nxm}, 3'b100);
      do_start(2'b01, 16'hFFF0, 22'd0, 1'b0, {8'd203, 1'b0, 4'd0});
      wait_done(50, ok);
      chk("nxc_done", ok, 1);
      chk("nxc_err", {err_nxs, err_nxc}, 2'b01);
      chk("nx_noreq", {fill_cnt[3:0], flush_cnt[3:0], hs_cnt[3:0]}, 0);

      // ---- write check, inh_ba, mismatch on 5th word
      clr_models();
      rd_mode = 1'b1;
      bad_idx = 4;
      do_start(2'b11, 16'hFFF0, 22'h002000, 1'b1, 13'd0);
      wait_done(3000, ok);
      chk("wc_done", ok, 1);
      chk("wc_err", {err_wce, err_nxc}, 2'b10);
      chk("wc_wc", wc_out, 16'hFFF5);
      chk("wc_ba", ba_out, 22'h002000);
      chk("wc_hs", hs_cnt, 5);
      bad = 0;
      for (int k = 0; k < 5; k++) if (alog[k] !== 22'h002000) bad++;
      chk("wc_addr_hold", bad, 0);
      rd_mode = 1'b0;

      // ---- func 00 is ignored
      clr_models();
      do_start(2'b00, 16'hFFF0, 22'd0, 1'b0, 13'd0);
      repeat (3) @(negedge qclk);
      chk("f0_idle", {busy, sect_req, dma_req}, 0);

      // ---- init_L mid-transfer clears outputs at once
      do_start(2'b10, 16'hFFF0, 22'h000100, 1'b0, 13'd0);
      repeat (12) @(negedge qclk);
      #5 init_L = 1'b0;
      #1;
      chk("ar_outs", {busy, sect_req, dma_req, done}, 0);
      chk("ar_ctrs", {wc_out, ba_out} != 0, 0);
      @(negedge qclk);
      init_L = 1'b1;
      clr_models();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
